adc_axis_src: RTL

- Behavioural ADC model: the other end of the DAC path. It samples a real-valued analog input, quantizes it to signed two's-complement codes and streams them out as an AXI4-Stream master.
- Quantization is the exact inverse of the DAC scaling (code = ain/VREF * 2^(BITS-1)), so a DAC-to-ADC loopback returns the original code.
- Includes a programmable decimation strobe and a small first-word-fall-through (FWFT) FIFO that absorbs downstream backpressure, with overflow accounting.
- Used in testbenches as the readout/ADC stand-in for loopback checks.

---
 rtl/adc_pkg.sv | 24 ++
 rtl/adc_axis_src_fifo.sv | 73 +++++++
 rtl/adc_axis_src.sv | 97 +++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared ADC definitions: drop-counter width and the ain-to-code quantizer
// (also used by scoreboards so model and hardware agree on rounding).
package adc_pkg;

   localparam int unsigned DROP_W = 16;

   // Round half away from zero, then saturate to the signed range of 'bits'.
   function automatic longint quantize(input real ain, input real vref, input int bits);
      real    scale;
      real    x;
      real    r;
      longint lim;
      scale = 1.0;
      for (int i = 0; i < bits - 1; i++) scale = scale * 2.0;
      lim = longint'(1) <<< (bits - 1);
      x   = ain / vref * scale;
      if (x >= 0.0) r = $floor(x + 0.5);
      else          r = -$floor(-x + 0.5);
      if (r > real'(lim - 1)) return lim - 1;
      if (r < -real'(lim))    return -lim;
      return longint'(r);
   endfunction

endpackage

// File: rtl/adc_axis_src_fifo.sv
// Generic synchronous first-word-fall-through FIFO with a registered head
// word; level is tracked separately so full and empty are unambiguous.
module sample_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic [WIDTH-1:0] r_dout;
   logic             r_full;
   logic             r_empty;

   logic             w_pop;
   logic             w_push;
   logic [AW-1:0]    w_rd_nxt;
   logic [LW-1:0]    w_level_nxt;

   // A push into a full FIFO is only accepted when a pop frees a slot.
   assign w_pop       = pop && !r_empty;
   assign w_push      = push && (!r_full || w_pop);
   assign w_rd_nxt    = r_rd_ptr + AW'(1);
   assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_dout   <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= w_rd_nxt;
         r_level <= w_level_nxt;
         r_full  <= (w_level_nxt == LW'(DEPTH));
         r_empty <= (w_level_nxt == '0);
         // Head register tracks the next oldest entry; holds when draining to empty.
         if (w_pop) begin
            if (r_level > LW'(1)) r_dout <= r_mem[w_rd_nxt];
            else if (w_push)      r_dout <= din;
         end else if (r_empty && w_push) begin
            r_dout <= din;
         end
      end
   end

   assign dout  = r_dout;
   assign full  = r_full;
   assign empty = r_empty;
   assign level = r_level;

endmodule

// File: rtl/adc_axis_src.sv
// Behavioural ADC: decimated sampling of a real input, quantized to signed
// codes and streamed through a small FWFT FIFO as an AXI4-Stream master.
module adc_axis_src
   import adc_pkg::*;
#(
   parameter int unsigned BITS  = 16,
   parameter real         VREF  = 1.0,
   parameter int unsigned DECIM = 1,
   parameter int unsigned DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        aresetn,
   input  logic                        en,
   input  real                         ain,
   input  logic                        ovf_clr,
   output logic signed [BITS-1:0]      m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        ovf,
   output logic [DROP_W-1:0]           drop_cnt,
   output logic [$clog2(DEPTH):0]      level
);

   localparam int unsigned DW = (DECIM > 1) ? $clog2(DECIM) : 1;

   logic [DW-1:0]     r_dcnt;
   logic              r_ovf;
   logic [DROP_W-1:0] r_drop_cnt;

   logic              w_samp;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic              w_drop;
   logic [BITS-1:0]   w_code;
   logic [BITS-1:0]   w_dout;
   logic              w_ovf_nxt;
   logic [DROP_W-1:0] w_drop_nxt;

   // Decimation counter: forced to zero while disabled so enabling samples at once.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn)                      r_dcnt <= '0;
      else if (!en)                      r_dcnt <= '0;
      else if (r_dcnt == DW'(DECIM - 1)) r_dcnt <= '0;
      else                               r_dcnt <= r_dcnt + DW'(1);
   end

   assign w_samp = en && (r_dcnt == '0);
   assign w_code = BITS'(quantize(ain, VREF, int'(BITS)));
   assign w_pop  = m_axis_tvalid && m_axis_tready;
   assign w_drop = w_samp && w_full && !w_pop;

   sample_fifo #(
      .WIDTH (BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (aresetn),
      .push  (w_samp),
      .din   (w_code),
      .pop   (w_pop),
      .dout  (w_dout),
      .full  (w_full),
      .empty (w_empty),
      .level (level)
   );

   // Overflow accounting: a drop in the same cycle as a clear still registers.
   always_comb begin
      w_ovf_nxt  = r_ovf;
      w_drop_nxt = r_drop_cnt;
      if (ovf_clr) begin
         w_ovf_nxt  = 1'b0;
         w_drop_nxt = '0;
      end
      if (w_drop) begin
         w_ovf_nxt = 1'b1;
         if (w_drop_nxt != '1) w_drop_nxt = w_drop_nxt + DROP_W'(1);
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_ovf      <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_ovf      <= w_ovf_nxt;
         r_drop_cnt <= w_drop_nxt;
      end
   end

   assign m_axis_tdata  = w_dout;
   assign m_axis_tvalid = !w_empty;
   assign ovf           = r_ovf;
   assign drop_cnt      = r_drop_cnt;

endmodule
